// File: rtl/eth_axil_pkg.sv
// Shared types and constants for the AXI-Lite write arbiter.
// State encoding, BRESP codes and bus widths.
package eth_axil_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_e;

endpackage

// File: rtl/axil_write_arbiter_if.sv
// AXI-Lite write channel bundle (AW, W, B).
// Master drives address/data/bready, slave drives the rest.
interface axil_write_arbiter_if;
  import eth_axil_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// scanning circularly upward from ptr.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  // Circular priority scan starting at ptr
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axil_write_arbiter.sv
// Shares one AXI-Lite write master among N_REQ requesters,
// round-robin, one outstanding write, per-requester done pulse.
module axil_write_arbiter
  import eth_axil_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_data,
  input  logic [4*N_REQ-1:0]    req_strb,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      req_done,
  output logic [1:0]            req_resp,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [AXI_ADDR_W-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [AXI_DATA_W-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [31:0]          awaddr_q, awaddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic [N_REQ-1:0]     ready_q, ready_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic [1:0]           resp_q, resp_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic [N_REQ-1:0]     gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 aw_done, w_done;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    g_d       = g_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    ready_d   = '0;
    done_d    = '0;
    resp_d    = resp_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          g_d       = gnt_idx;
          awaddr_d  = req_addr[32*int'(gnt_idx) +: 32];
          wdata_d   = req_data[32*int'(gnt_idx) +: 32];
          wstrb_d   = req_strb[4*int'(gnt_idx) +: 4];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          ready_d   = gnt;
          state_d   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          done_d[g_q] = 1'b1;
          resp_d      = M_AXI_BRESP;
          if (M_AXI_BRESP != AXI_RESP_OKAY && err_q != '1)
            err_d = err_q + ERR_CNT_W'(1);
          rr_ptr_d = (g_q == IDX_W'(N_REQ-1)) ? '0
                                              : g_q + IDX_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      g_q       <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      ready_q   <= '0;
      done_q    <= '0;
      resp_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      g_q       <= g_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign req_ready     = ready_q;
  assign req_done      = done_q;
  assign req_resp      = resp_q;
  assign busy          = busy_q;
  assign err_count     = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule
